// File: rtl/seq_mem_target.sv
// seq_mem_target: memory-side responder for the CPU external bus.
//
// Decodes the CPU address window, stretches the CPU cycle with wait_n and runs
// exactly one backend access per CPU request over a req/ack handshake. All
// outputs are registered.
//
// Ports:
//   clk, res                 clock, synchronous active-high reset
//   mreq_n, rd, wr, a, d_in  CPU request side (mreq_n active low)
//   d_out, d_oe              read data to CPU and its valid/drive enable
//   wait_n                   low stalls the CPU
//   sel                      high while this block owns a transaction
//   mem_req, mem_we          backend request and write enable
//   mem_addr, mem_wdata      backend address and write data
//   mem_ack, mem_rdata       backend single-cycle ack and read data
//   timeout                  one-cycle pulse when the backend never answers
module seq_mem_target #(
  parameter logic [15:0] BASE     = 16'hC000,
  parameter logic [15:0] MASK     = 16'hE000,
  parameter int unsigned AW       = 13,
  parameter int unsigned WAIT_MIN = 1,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          res,
  input  logic          mreq_n,
  input  logic          rd,
  input  logic          wr,
  input  logic [15:0]   a,
  input  logic [7:0]    d_in,
  output logic [7:0]    d_out,
  output logic          d_oe,
  output logic          wait_n,
  output logic          sel,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic          timeout
);

  localparam logic [3:0] WaitInit   = 4'(WAIT_MIN);
  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StSetup, StReq, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic            mreq_q;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [7:0]      tcnt_q, tcnt_d, tcnt_inc;
  logic [7:0]      d_out_q, d_out_d;
  logic            d_oe_q, d_oe_d;
  logic            wait_n_q, wait_n_d;
  logic            sel_q, sel_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            timeout_q, timeout_d;
  logic            start;

  // Falling-edge detect on mreq_n; mreq_q resets low so a request already
  // asserted at reset release is not taken.
  assign start = mreq_q & ~mreq_n & (rd ^ wr) & ((a & MASK) == BASE);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    tcnt_inc    = tcnt_q + 8'd1;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    wait_n_d    = wait_n_q;
    sel_d       = sel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mem_addr_d  = a[AW-1:0];
          mem_we_d    = wr;
          mem_wdata_d = d_in;
          sel_d       = 1'b1;
          wait_n_d    = 1'b0;
          wcnt_d      = WaitInit;
          if (WAIT_MIN == 0) begin
            state_d   = StReq;
            mem_req_d = 1'b1;
            tcnt_d    = 8'd0;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StSetup: begin
        if (mreq_n) begin
          // CPU gave up before the backend was touched.
          state_d  = StIdle;
          sel_d    = 1'b0;
          wait_n_d = 1'b1;
        end else if (wcnt_q <= 4'd1) begin
          state_d   = StReq;
          mem_req_d = 1'b1;
          tcnt_d    = 8'd0;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StReq: begin
        tcnt_d = tcnt_inc;
        if (mem_ack) begin
          // Ack takes priority over a coincident timeout.
          mem_req_d = 1'b0;
          if (!mem_we_q) d_out_d = mem_rdata;
          d_oe_d    = ~mem_we_q;
          wait_n_d  = 1'b1;
          state_d   = StDone;
        end else if (tcnt_inc == TimeoutVal) begin
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
          d_out_d   = 8'hFF;
          d_oe_d    = ~mem_we_q;
          wait_n_d  = 1'b1;
          state_d   = StDone;
        end else if (mreq_n) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Request is never retracted: wait for ack (or timeout), drop the data.
        tcnt_d = tcnt_inc;
        if (mem_ack || (tcnt_inc == TimeoutVal)) begin
          mem_req_d = 1'b0;
          timeout_d = ~mem_ack;
          sel_d     = 1'b0;
          wait_n_d  = 1'b1;
          state_d   = StIdle;
        end
      end
      StDone: begin
        if (mreq_n) begin
          d_oe_d  = 1'b0;
          sel_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= StIdle;
      mreq_q      <= 1'b0;
      wcnt_q      <= 4'd0;
      tcnt_q      <= 8'd0;
      d_out_q     <= 8'h00;
      d_oe_q      <= 1'b0;
      wait_n_q    <= 1'b1;
      sel_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mreq_q      <= mreq_n;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      wait_n_q    <= wait_n_d;
      sel_q       <= sel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign d_out     = d_out_q;
  assign d_oe      = d_oe_q;
  assign wait_n    = wait_n_q;
  assign sel       = sel_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign timeout   = timeout_q;

endmodule
